// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the latch-based register file: in-order FIFO of ALU/load
// results, setup/strobe/hold write sequencing, and a pending-write scoreboard.
//
//  state  | meaning
//  IDLE   | nothing in flight; pop head when FIFO non-empty
//  SETUP  | dest/data driven and stable, write enable low
//  STROBE | write enable high for one cycle, pending bit cleared
//  HOLD   | write enable low, dest/data held; chain to next entry if any
module regfile_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int NREGS = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid_in,
    output logic             alu_ready_out,
    input  logic [4:0]       alu_dest_in,
    input  logic [31:0]      alu_data_in,
    input  logic             mem_valid_in,
    output logic             mem_ready_out,
    input  logic [4:0]       mem_dest_in,
    input  logic [31:0]      mem_data_in,
    input  logic             issue_valid_in,
    input  logic [4:0]       issue_dest_in,
    output logic [4:0]       rf_dest_out,
    output logic [31:0]      rf_data_out,
    output logic             rf_wen_out,
    output logic [NREGS-1:0] pending_out,
    output logic             busy_out,
    output logic             drop_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state, state_nx;
    logic [4:0]        fifo_dest [DEPTH];
    logic [31:0]       fifo_data [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, alu_slot;
    logic [CW-1:0]     count, push_n;
    logic              mem_push, alu_push, pop, head_ok, load_out;
    logic [NREGS-1:0]  pending_nx;

    // Mem takes priority for the last free slot so both sources never overflow it.
    assign mem_ready_out = (count <= CW'(DEPTH - 1));
    assign alu_ready_out = (count <= CW'(DEPTH - 2)) ||
                           ((count == CW'(DEPTH - 1)) && !mem_valid_in);
    assign mem_push = mem_valid_in && mem_ready_out;
    assign alu_push = alu_valid_in && alu_ready_out;
    assign push_n   = CW'(mem_push) + CW'(alu_push);
    assign alu_slot = mem_push ? wr_ptr + AW'(1) : wr_ptr;
    assign head_ok  = (fifo_dest[rd_ptr] != 5'd0) && (fifo_dest[rd_ptr] < 5'(NREGS));
    assign drop_out = pop && !head_ok;
    assign busy_out = (count != '0) || (state != IDLE);

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load_out = 1'b0;
        case (state)
            IDLE, HOLD: begin
                state_nx = IDLE;
                if (count != '0) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        load_out = 1'b1;
                        state_nx = SETUP;
                    end
                end
            end
            SETUP:   state_nx = STROBE;
            STROBE:  state_nx = HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // A same-cycle issue beats the strobe clear: a newer producer owns the register.
    always_comb begin
        pending_nx = pending_out;
        if (state == STROBE)
            pending_nx[rf_dest_out] = 1'b0;
        if (issue_valid_in && (issue_dest_in != 5'd0) && (issue_dest_in < 5'(NREGS)))
            pending_nx[issue_dest_in] = 1'b1;
        pending_nx[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            fifo_dest[wr_ptr] <= mem_dest_in;
            fifo_data[wr_ptr] <= mem_data_in;
        end
        if (alu_push) begin
            fifo_dest[alu_slot] <= alu_dest_in;
            fifo_data[alu_slot] <= alu_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rf_dest_out <= '0;
            rf_data_out <= '0;
            rf_wen_out  <= 1'b0;
            pending_out <= '0;
        end else begin
            state       <= state_nx;
            wr_ptr      <= wr_ptr + AW'(push_n);
            rd_ptr      <= rd_ptr + AW'(pop);
            count       <= count + push_n - CW'(pop);
            rf_wen_out  <= (state_nx == STROBE);
            pending_out <= pending_nx;
            if (load_out) begin
                rf_dest_out <= fifo_dest[rd_ptr];
                rf_data_out <= fifo_data[rd_ptr];
            end
        end
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller that sits on the write side of the 18-entry latch-based register file: R0 reads as zero, R1–R16 are general registers, and entry 17 is SP. It accepts write-back requests from the ALU and load/store paths over valid/ready handshakes and buffers them in an in-order FIFO. It then drives the register file's destination, data and write-enable lines with a glitch-free setup/strobe/hold sequence that is safe for level-sensitive latches. It also keeps a pending-write scoreboard that the issue logic uses to stall reads of registers still in flight.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- NREGS, 18, register-file entries including R0 (indices 0..17)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid_in  in  1  ALU write-back request valid
- alu_ready_out  out  1  ALU request accepted when valid&ready
- alu_dest_in  in  5  ALU destination register index
- alu_data_in  in  32  ALU result
- mem_valid_in  in  1  load write-back request valid
- mem_ready_out  out  1  load request accepted when valid&ready
- mem_dest_in  in  5  load destination register index
- mem_data_in  in  32  load data
- issue_valid_in  in  1  an instruction issued that will write issue_dest_in
- issue_dest_in  in  5  destination being reserved
- rf_dest_out  out  5  register-file write address
- rf_data_out  out  32  register-file write data
- rf_wen_out  out  1  register-file write enable (one-cycle strobe)
- pending_out  out  NREGS  scoreboard; bit i = write to register i outstanding
- busy_out  out  1  FIFO non-empty or FSM not IDLE
- drop_out  out  1  one-cycle pulse: an entry with invalid dest was discarded

## Operation
- Reset (asynchronous, rst_n=0): FIFO empty, FSM=IDLE, rf_dest_out=0, rf_data_out=0, rf_wen_out=0, pending_out=0, busy_out=0, drop_out=0.
- Acceptance: mem_ready_out = (count ≤ DEPTH-1). alu_ready_out = (count ≤ DEPTH-2) or (count == DEPTH-1 and !mem_valid_in). Readiness uses the count before any same-cycle pop. When both sources are accepted in the same cycle, the mem entry is enqueued ahead of the ALU entry.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if FIFO non-empty, pop the head into the output registers and go to SETUP; otherwise stay in IDLE.
  - SETUP: rf_dest_out and rf_data_out are stable, rf_wen_out=0; go to STROBE.
  - STROBE: rf_wen_out=1 for exactly one cycle; clear pending bit rf_dest_out; go to HOLD.
  - HOLD: rf_wen_out=0 with dest and data unchanged. If the FIFO is non-empty, pop and go to SETUP; otherwise go to IDLE.
- rf_dest_out and rf_data_out change only on entry to SETUP and hold their last values in IDLE.
- Invalid destination (dest 0 or dest > 17): the entry is popped but never strobed; drop_out pulses on the pop cycle, and the FSM stays in or returns to IDLE/HOLD flow without entering SETUP.
- Scoreboard: issue_valid_in with a valid nonzero dest sets that pending bit. Bit 0 is always 0. When a set and a STROBE clear hit the same register in the same cycle, the set wins (a newer producer exists). Issue to an invalid dest is ignored.
- Ordering: writes reach the register file in FIFO order. A later write to the same register overwrites an earlier one.

## Timing
- Minimum latency: request accepted at edge N → SETUP in cycle N+2, rf_wen_out high in cycle N+3.
- Sustained throughput: one register write per 3 cycles (SETUP, STROBE, HOLD); back-to-back entries chain HOLD→SETUP with no IDLE cycle.
- rf_wen_out is a registered output, never combinationally derived, and is high only in STROBE.
- Push and pop in the same cycle are allowed; count is updated by both.
- Reset asserted mid-sequence (including during STROBE): rf_wen_out drops immediately, FIFO contents and the scoreboard are lost, and the FSM restarts in IDLE.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release, then one ALU write of R5=0x1234_5678 → rf_wen_out high exactly in cycle N+3 with dest=5; pending[5] clears in the same cycle.
- Simultaneous sources with count=0: mem (R3=0xAAAA_0000) and ALU (R3=0x5555_0000) in one cycle → mem strobe first, then ALU strobe; the final register-file value of R3 is 0x5555_0000.
- Full FIFO, DEPTH=4: push 4 entries without draining → alu_ready_out=0 and mem_ready_out=0 at count 4. Observe 4 strobes spaced exactly 3 cycles apart.
- Invalid destinations: a write to R0, then to dest 20 → no rf_wen_out pulse and two drop_out pulses; the following valid write to R17 (SP)=0xFFFF_FFF0 strobes normally.
- Scoreboard race: issue R7 in the same cycle as the STROBE for R7 → pending[7] stays 1 and clears only on the next R7 strobe.
- Reset during STROBE with 2 entries queued → rf_wen_out falls asynchronously; after release, busy_out=0 and pending_out=0.
